// File: rtl/linebuf3_ctrl.sv
// Line-buffer sequencer for three 1-bit simple dual-port RAMs: rotates the write
// target per line and aligns rows y-2, y-1 and y into a 3-bit column.
module linebuf3_ctrl #(
  parameter int IMG_WIDTH_LINE = 1920,
  parameter int ADDR_W         = 12
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic              pix_data,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [ADDR_W-1:0] ram_addrb,
  output logic              ram_dina,
  output logic [2:0]        ram_wea,
  input  logic [2:0]        ram_doutb,
  output logic              col_top,
  output logic              col_mid,
  output logic              col_bot,
  output logic              col_valid,
  output logic              col_rows_ok,
  output logic [ADDR_W-1:0] col_x,
  output logic              col_eol
);

  localparam logic [ADDR_W-1:0] LAST_X = ADDR_W'(IMG_WIDTH_LINE - 1);

  function automatic logic [1:0] inc3(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic [ADDR_W-1:0] x_cnt, x_nxt, eff_x;
  logic [1:0]        wr_sel, sel_nxt, eff_sel;
  logic [1:0]        row_cnt, row_nxt, eff_row;
  logic              restart, at_eol;

  logic              valid_d1, pix_d1, eol_d1, rows_ok_d1;
  logic [1:0]        sel_d1;
  logic [ADDR_W-1:0] x_d1;
  logic              top_rd, mid_rd;

  // NOTE: every signal driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    restart   = pix_valid & pix_sof;
    eff_x     = restart ? '0 : x_cnt;
    eff_sel   = restart ? 2'd0 : wr_sel;
    eff_row   = restart ? 2'd0 : row_cnt;
    at_eol    = (eff_x == LAST_X);

    ram_addra = eff_x;
    ram_addrb = eff_x;
    ram_dina  = pix_data;
    ram_wea   = pix_valid ? (3'b001 << eff_sel) : 3'b000;

    x_nxt     = x_cnt;
    sel_nxt   = wr_sel;
    row_nxt   = row_cnt;
    if (pix_valid) begin
      if (at_eol) begin
        x_nxt   = '0;
        sel_nxt = inc3(eff_sel);
        row_nxt = (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
      end else begin
        x_nxt   = eff_x + ADDR_W'(1);
        sel_nxt = eff_sel;
        row_nxt = eff_row;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      wr_sel  <= 2'd0;
      row_cnt <= 2'd0;
    end else begin
      x_cnt   <= x_nxt;
      wr_sel  <= sel_nxt;
      row_cnt <= row_nxt;
    end
  end

  // Stage 1 runs alongside the RAM's registered read of the same address.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      valid_d1   <= 1'b0;
      pix_d1     <= 1'b0;
      sel_d1     <= 2'd0;
      x_d1       <= '0;
      eol_d1     <= 1'b0;
      rows_ok_d1 <= 1'b0;
    end else begin
      valid_d1 <= pix_valid;
      if (pix_valid) begin
        pix_d1     <= pix_data;
        sel_d1     <= eff_sel;
        x_d1       <= eff_x;
        eol_d1     <= at_eol;
        rows_ok_d1 <= (eff_row == 2'd2);
      end
    end
  end

  // Top row sits in the RAM after the write target, mid row in the one before it.
  always_comb begin
    top_rd = ram_doutb[1];
    mid_rd = ram_doutb[2];
    case (sel_d1)
      2'd1:    begin top_rd = ram_doutb[2]; mid_rd = ram_doutb[0]; end
      2'd2:    begin top_rd = ram_doutb[0]; mid_rd = ram_doutb[1]; end
      default: begin top_rd = ram_doutb[1]; mid_rd = ram_doutb[2]; end
    endcase
  end

  // NOTE: the RAM arrays themselves are never reset; col_rows_ok marks when their
  // contents are meaningful, and only this controller's registers clear.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      col_valid   <= 1'b0;
      col_top     <= 1'b0;
      col_mid     <= 1'b0;
      col_bot     <= 1'b0;
      col_x       <= '0;
      col_eol     <= 1'b0;
      col_rows_ok <= 1'b0;
    end else begin
      col_valid <= valid_d1;
      if (valid_d1) begin
        col_top     <= top_rd;
        col_mid     <= mid_rd;
        col_bot     <= pix_d1;
        col_x       <= x_d1;
        col_eol     <= eol_d1;
        col_rows_ok <= rows_ok_d1;
      end
    end
  end

endmodule

// File: tb/tb_linebuf3_ctrl.sv
// Self-checking bench for linebuf3_ctrl with an 8-pixel line and three behavioural
// RAMs; expected columns come from a reference image kept by the bench.
module tb_linebuf3_ctrl;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0, pix_sof = 1'b0, pix_data = 1'b0;
  logic [AW-1:0] ram_addra, ram_addrb, col_x;
  logic          ram_dina, col_top, col_mid, col_bot, col_valid, col_rows_ok, col_eol;
  logic [2:0]    ram_wea, ram_doutb;

  linebuf3_ctrl #(.IMG_WIDTH_LINE(W), .ADDR_W(AW)) dut (
    .clka(clka), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .ram_addra(ram_addra), .ram_addrb(ram_addrb),
    .ram_dina(ram_dina), .ram_wea(ram_wea), .ram_doutb(ram_doutb),
    .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot), .col_valid(col_valid),
    .col_rows_ok(col_rows_ok), .col_x(col_x), .col_eol(col_eol)
  );

  always #5 clka = ~clka;

  // Behavioural 1-bit simple dual-port RAMs: synchronous write, registered read.
  logic [15:0] mem [3];
  always @(posedge clka) begin
    for (int i = 0; i < 3; i++) begin
      if (ram_wea[i]) mem[i][ram_addra] <= ram_dina;
      ram_doutb[i] <= mem[i][ram_addrb];
    end
  end

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] x;
    logic          eol, rows_ok, top, mid, bot;
  } col_t;

  typedef struct packed {
    logic          valid, sof, data;
    logic [2:0]    wea;
    logic [AW-1:0] addr;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_x = 0, m_y = 0;
  logic img [16][W];
  col_t e1 = '0, e2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] row_wea(input int y);
    case (y % 3)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // One cycle: drive inputs just after a rising edge, check on the falling edge.
  task automatic step(input logic v, input logic s, input logic d,
                      output logic [2:0] wea_s, output logic [AW-1:0] addr_s);
    col_t cur;
    pix_valid = v; pix_sof = s; pix_data = d;
    @(negedge clka);
    wea_s = ram_wea; addr_s = ram_addra;
    if (v && s) begin m_x = 0; m_y = 0; end
    if (v) begin
      check("wea_onehot", 32'(ram_wea), 32'(row_wea(m_y)));
      check("addra", 32'(ram_addra), 32'(m_x));
      check("addrb", 32'(ram_addrb), 32'(m_x));
      check("dina", 32'(ram_dina), 32'(d));
    end else begin
      check("wea_idle", 32'(ram_wea), 32'd0);
    end
    check("col_valid", 32'(col_valid), 32'(e2.valid));
    if (e2.valid) begin
      check("col_x", 32'(col_x), 32'(e2.x));
      check("col_eol", 32'(col_eol), 32'(e2.eol));
      check("col_rows_ok", 32'(col_rows_ok), 32'(e2.rows_ok));
      check("col_bot", 32'(col_bot), 32'(e2.bot));
      if (e2.rows_ok) begin
        check("col_top", 32'(col_top), 32'(e2.top));
        check("col_mid", 32'(col_mid), 32'(e2.mid));
      end
    end
    cur = '0;
    if (v) begin
      img[m_y][m_x] = d;
      cur.valid   = 1'b1;
      cur.x       = AW'(m_x);
      cur.eol     = (m_x == W - 1);
      cur.rows_ok = (m_y >= 2);
      cur.bot     = d;
      if (m_y >= 2) begin
        cur.top = img[m_y-2][m_x];
        cur.mid = img[m_y-1][m_x];
      end
      if (m_x == W - 1) begin m_x = 0; m_y = (m_y < 15) ? m_y + 1 : 15; end
      else m_x = m_x + 1;
    end
    @(posedge clka); #1;
    e2 = e1; e1 = cur;
  endtask

  task automatic px(input logic v, input logic s, input logic d);
    logic [2:0]    w;
    logic [AW-1:0] a;
    step(v, s, d, w, a);
  endtask

  task automatic run_line(input logic [7:0] pat, input logic sof_first,
                          input int gap_pct, input int npix);
    for (int i = 0; i < npix; i++) begin
      while ($urandom_range(0, 99) < gap_pct) px(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      px(1'b1, sof_first && (i == 0), pat[7-i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_col_valid"}, 32'(col_valid), 32'd0);
    check({tag, "_col_bits"}, 32'({col_top, col_mid, col_bot}), 32'd0);
    check({tag, "_col_x"}, 32'(col_x), 32'd0);
    check({tag, "_col_flags"}, 32'({col_eol, col_rows_ok}), 32'd0);
    check({tag, "_wea"}, 32'(ram_wea), 32'd0);
    check({tag, "_addra"}, 32'(ram_addra), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl [9];
    logic [2:0]    w;
    logic [AW-1:0] a;

    // Line 0 = 10110010 with one bubble (whose data must be ignored) before x=3.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 3'b001, 4'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 3'b001, 4'd1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 3'b001, 4'd2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 3'b000, 4'd3};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 3'b001, 4'd3};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 3'b001, 4'd4};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 3'b001, 4'd5};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 3'b001, 4'd6};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 3'b001, 4'd7};

    #12;
    check_all_zero("reset");
    @(negedge clka); rst_n = 1'b1;
    @(posedge clka); #1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].valid, tbl[i].sof, tbl[i].data, w, a);
      check($sformatf("tbl%0d_wea", i), 32'(w), 32'(tbl[i].wea));
      check($sformatf("tbl%0d_addr", i), 32'(a), 32'(tbl[i].addr));
    end

    // Lines B, C (line 2 sees A/B as top/mid), then line 3 writes RAM 0 again.
    run_line(8'b01101100, 1'b0, 0, 8);
    run_line(8'b11100101, 1'b0, 0, 8);
    run_line(8'b00111010, 1'b0, 0, 8);
    run_line(8'b10011001, 1'b0, 0, 8);

    // Five lines with random bubbles; the row counter saturates throughout.
    for (int l = 0; l < 5; l++) run_line(8'($urandom()), 1'b0, 50, 8);

    // New frame, then sof arrives at x=5 of line 3.
    run_line(8'b11010011, 1'b1, 0, 8);
    run_line(8'b00101101, 1'b0, 0, 8);
    run_line(8'b10101010, 1'b0, 0, 8);
    run_line(8'b01110001, 1'b0, 0, 5);
    step(1'b1, 1'b1, 1'b1, w, a);
    check("midsof_wea", 32'(w), 32'(3'b001));
    check("midsof_addr", 32'(a), 32'd0);
    run_line(8'b11001011, 1'b0, 0, 7);
    run_line(8'b01011110, 1'b0, 0, 8);
    run_line(8'b10110111, 1'b0, 30, 8);

    // Asynchronous reset pulse mid-line, not aligned to the clock.
    run_line(8'b11111111, 1'b0, 0, 4);
    pix_valid = 1'b0; pix_sof = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    #9 rst_n = 1'b1;
    @(posedge clka); #1;
    m_x = 0; m_y = 0; e1 = '0; e2 = '0;
    step(1'b1, 1'b0, 1'b1, w, a);
    check("postrst_wea", 32'(w), 32'(3'b001));
    check("postrst_addr", 32'(a), 32'd0);
    run_line(8'b01100110, 1'b0, 0, 7);
    run_line(8'b10010110, 1'b0, 0, 8);
    run_line(8'b00011111, 1'b0, 0, 8);

    px(1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linebuf3_ctrl.md
Name: linebuf3_ctrl

Overview:
- Sequences three 1-bit line-buffer RAMs. Each RAM is simple dual-port: 1-cycle registered read and synchronous write.
- Together they form a 3-row sliding column for 3x3 binary morphology (erode/dilate) on a raster pixel stream.
- Rotates the write target per line and generates shared write/read addresses.
- Aligns the two delayed rows with the live pixel and outputs a 3-bit column plus coordinates to the downstream window/filter stage.

Parameters:
- IMG_WIDTH_LINE, 1920, pixels per line (RAM depth); must be >= 2.
- ADDR_W, 12, RAM address width; 2^ADDR_W >= IMG_WIDTH_LINE.

Ports:
- clka  in  1  clock, shared with the three RAMs
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  input pixel strobe; one pixel accepted per cycle when high
- pix_sof  in  1  start of frame, qualified by pix_valid; marks pixel (0,0)
- pix_data  in  1  binary pixel
- ram_addra  out  ADDR_W  write address, common to all three RAMs
- ram_addrb  out  ADDR_W  read address, common to all three RAMs
- ram_dina  out  1  write data, common to all three RAMs
- ram_wea  out  3  one-hot write enable, bit i drives RAM i
- ram_doutb  in  3  read data, bit i from RAM i
- col_top  out  1  pixel at (x, y-2)
- col_mid  out  1  pixel at (x, y-1)
- col_bot  out  1  pixel at (x, y)
- col_valid  out  1  column strobe
- col_rows_ok  out  1  high when y >= 2, i.e. top/mid are real data
- col_x  out  ADDR_W  column index x of the output column
- col_eol  out  1  high with the last column of a line (x = IMG_WIDTH_LINE-1)

Behaviour:
- Reset (async, rst_n=0):
  - all outputs and internal registers go to 0: x_cnt=0, wr_sel=0, row_cnt=0, pipeline valids=0.
  - RAM contents are not relied on; col_rows_ok gates them.
- Accept cycle (pix_valid=1), combinational from current state:
  - ram_addra = ram_addrb = x_cnt; ram_dina = pix_data; ram_wea = one-hot(wr_sel).
  - Read and write always target different RAMs, so there is no read/write collision.
  - When pix_valid=0: ram_wea=0 and all counters hold. Bubbles are allowed anywhere.
- pix_sof=1 with pix_valid=1:
  - the pixel is treated as x=0, row 0, wr_sel=0, regardless of counter state.
  - it is written to RAM 0 at address 0; next state is x_cnt=1, row_cnt=0.
  - pix_sof has priority over wrap. pix_sof with pix_valid=0 is ignored.
- Counter update after an accepted pixel:
  - x_cnt increments. At x_cnt = IMG_WIDTH_LINE-1 it wraps to 0.
  - On wrap: wr_sel rotates 0->1->2->0; row_cnt increments, saturating at 2.
- Row mapping at read time:
  - RAM (wr_sel+1) mod 3 holds row y-2 (top).
  - RAM (wr_sel+2) mod 3 holds row y-1 (mid).
- Pipeline, fixed latency 2 cycles from accept to col_valid:
  - Stage 1 (registered at accept): valid_d1, pix_d1, sel_d1=wr_sel, x_d1, eol_d1, rows_ok_d1=(row_cnt==2).
  - Stage 2 (registered): col_top = ram_doutb[(sel_d1+1)%3], col_mid = ram_doutb[(sel_d1+2)%3], col_bot = pix_d1; col_x, col_eol, col_rows_ok from stage 1; col_valid = valid_d1.
  - Stage 2 registers data only when valid_d1=1 and otherwise hold; col_valid follows valid_d1 every cycle.
- Output strobes:
  - col_valid is emitted for every accepted pixel, including rows 0 and 1, where col_rows_ok=0. Downstream applies the border policy.
  - col_eol is set exactly when x = IMG_WIDTH_LINE-1.
- Mid-frame sof: counters restart immediately. In-flight pipeline outputs still emerge with their original coordinates. The following 2 lines report col_rows_ok=0.
- Reset mid-operation: the pipeline is flushed, and the first valid after reset is treated as x=0, row 0 even without pix_sof.

Test Plan:
- IMG_WIDTH_LINE=8. sof, then 8 continuous pixels of pattern 10110010 -> ram_wea=001 for all 8, addra 0..7; col_valid at accept+2 with col_bot matching the pattern; col_eol only on x=7; col_rows_ok=0.
- Three full lines A, B, C (distinct patterns) -> line 3 outputs col_top=A[x], col_mid=B[x], col_bot=C[x], col_rows_ok=1; line 4 writes RAM 0 (wea=001) with top=B, mid=C.
- Random pix_valid gaps (~50% duty) over 5 lines -> column data identical to the gapless run; counters frozen during gaps; each col_valid exactly 2 cycles after its accept.
- pix_sof asserted at x=5 of line 3 -> that pixel written to RAM 0 addr 0; the next 2 lines have col_rows_ok=0; no wea bit other than the one-hot target ever asserted.
- rst_n pulsed low mid-line for 1 cycle (not clock-aligned) -> all outputs 0 immediately; next accepted pixel goes to addr 0 with wea=001.
- Check every accept cycle -> wea is one-hot, and the written RAM index is never the same as the top or mid read RAM index.
